// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor and IF/DEC flush sequencer.
//   * Fetch side: a table of 2^INDEX_BITS 2-bit saturating counters is looked up
//     combinationally with IF_PC; `prediction` is the counter MSB.
//   * EX side: resolved conditional branches train the table, a resolution that
//     disagrees with the prediction carried down the pipe raises `mispredict`,
//     and `flush` is held for FLUSH_CYCLES non-stalled cycles.
//
// Parameters:
//   DBITS        PC / datapath width
//   INDEX_BITS   log2 of the number of table entries
//   FLUSH_CYCLES cycles `flush` stays high per mispredict (1..8)
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   stall            freezes table, FSM, flush counter and statistics
//   IF_PC            fetch address used for the lookup
//   prediction       predicted-taken for IF_PC (combinational)
//   EX_valid         EX stage holds a real instruction
//   EX_isBranch      EX instruction is a conditional branch
//   EX_PC            PC+4 of the EX instruction
//   EX_taken         resolved branch outcome
//   EX_prediction    prediction that travelled with the branch
//   mispredict       EX branch resolved opposite to its prediction
//   flush            clear IF and DEC pipeline registers
//   branch_count     resolved branches (saturating statistic)
//   mispredict_count mispredictions (saturating statistic)
//
// Configuration macro:
//   BP_STATS_EN  when defined, builds the two saturating statistics counters;
//                otherwise both statistics outputs are tied to zero.
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int DBITS        = 32,
    parameter int INDEX_BITS   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [DBITS-1:0] IF_PC,
    output logic             prediction,
    input  logic             EX_valid,
    input  logic             EX_isBranch,
    input  logic [DBITS-1:0] EX_PC,
    input  logic             EX_taken,
    input  logic             EX_prediction,
    output logic             mispredict,
    output logic             flush,
    output logic [15:0]      branch_count,
    output logic [15:0]      mispredict_count
);

    localparam int         ENTRIES  = 1 << INDEX_BITS;
    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] rd_idx;
    logic [INDEX_BITS-1:0] wr_idx;
    logic [DBITS-1:0]      ex_pc_m4;
    logic                  upd;

    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'd1;
        end
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Lookup reads the registered table, so a same-cycle update to the same
    // entry is seen only on the following cycle (no bypass).
    assign rd_idx     = IF_PC[INDEX_BITS+1:2];
    assign prediction = table_q[rd_idx][1];

    // EX_PC is PC+4; recover the branch's own address before indexing.
    assign ex_pc_m4 = EX_PC - DBITS'(4);
    assign wr_idx   = ex_pc_m4[INDEX_BITS+1:2];

    // While flushing, whatever sits in EX is a bubble and must not train.
    assign upd        = EX_valid & EX_isBranch & ~stall & (state_q == IDLE);
    assign mispredict = upd & (EX_taken != EX_prediction);
    assign flush      = (state_q == FLUSH) | mispredict;

    // Only PC word-index bits address the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[DBITS-1:INDEX_BITS+2], IF_PC[1:0],
                              ex_pc_m4[DBITS-1:INDEX_BITS+2], ex_pc_m4[1:0]};

    // The mispredict cycle itself is the first flush cycle, so the counter is
    // loaded with FLUSH_CYCLES-1 and FLUSH is skipped entirely when that is 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (mispredict) begin
                    cnt_d   = CNT_INIT;
                    state_d = (CNT_INIT != 4'd0) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
        end else if (upd) begin
            table_q[wr_idx] <= ctr_step(table_q[wr_idx], EX_taken);
        end
    end

`ifdef BP_STATS_EN
    logic [15:0] branch_cnt_q;
    logic [15:0] misp_cnt_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // upd and mispredict already exclude stalled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_q <= 16'h0000;
            misp_cnt_q   <= 16'h0000;
        end else begin
            if (upd) begin
                branch_cnt_q <= sat_inc16(branch_cnt_q);
            end
            if (mispredict) begin
                misp_cnt_q <= sat_inc16(misp_cnt_q);
            end
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = misp_cnt_q;
`else
    assign branch_count     = 16'h0000;
    assign mispredict_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int DBITS        = 32;
    localparam int INDEX_BITS   = 4;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] IF_PC = 32'h0;
    logic        prediction;
    logic        EX_valid = 1'b0;
    logic        EX_isBranch = 1'b0;
    logic [31:0] EX_PC = 32'h0;
    logic        EX_taken = 1'b0;
    logic        EX_prediction = 1'b0;
    logic        mispredict;
    logic        flush;
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;

    always #5 clk = ~clk;

    branch_predictor #(
        .DBITS(DBITS),
        .INDEX_BITS(INDEX_BITS),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .IF_PC(IF_PC),
        .prediction(prediction),
        .EX_valid(EX_valid),
        .EX_isBranch(EX_isBranch),
        .EX_PC(EX_PC),
        .EX_taken(EX_taken),
        .EX_prediction(EX_prediction),
        .mispredict(mispredict),
        .flush(flush),
        .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    typedef struct {
        logic        pred;
        logic        mis;
        logic        fl;
        logic [15:0] bc;
        logic [15:0] mc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model state
    logic [1:0] m_tbl [16];
    logic       m_in_flush;
    int         m_cnt;
    int         m_bc;
    int         m_mc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
        m_in_flush = 1'b0;
        m_cnt = 0;
        m_bc = 0;
        m_mc = 0;
    endtask

    // One clock cycle with the currently driven inputs. xp/xf/xm are optional
    // hand-derived expectations (-1 = none) checked on top of the model.
    task automatic cyc(input string tag, input int xp, input int xf, input int xm);
        exp_t       e;
        logic       upd;
        logic [31:0] pcm4;
        logic [3:0] ui;
        logic [3:0] ri;
        ri   = IF_PC[5:2];
        pcm4 = EX_PC - 32'd4;
        ui   = pcm4[5:2];
        upd  = EX_valid && EX_isBranch && !stall && !m_in_flush;
        e.pred = m_tbl[ri][1];
        e.mis  = upd && (EX_taken != EX_prediction);
        e.fl   = m_in_flush || e.mis;
        e.bc   = 16'(m_bc);
        e.mc   = 16'(m_mc);
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_pred"}, 32'(prediction), 32'(e.pred));
        check({tag, "_mis"}, 32'(mispredict), 32'(e.mis));
        check({tag, "_flush"}, 32'(flush), 32'(e.fl));
        check({tag, "_bcnt"}, 32'(branch_count), 32'(e.bc));
        check({tag, "_mcnt"}, 32'(mispredict_count), 32'(e.mc));
        if (xp >= 0) check({tag, "_pred_k"}, 32'(prediction), 32'(xp));
        if (xf >= 0) check({tag, "_flush_k"}, 32'(flush), 32'(xf));
        if (xm >= 0) check({tag, "_mis_k"}, 32'(mispredict), 32'(xm));

        @(posedge clk);
        if (upd) begin
            if (EX_taken) m_tbl[ui] = (m_tbl[ui] == 2'd3) ? 2'd3 : m_tbl[ui] + 2'd1;
            else          m_tbl[ui] = (m_tbl[ui] == 2'd0) ? 2'd0 : m_tbl[ui] - 2'd1;
        end
        if (!m_in_flush) begin
            if (e.mis) begin
                m_cnt = FLUSH_CYCLES - 1;
                m_in_flush = (m_cnt != 0);
            end
        end else if (!stall) begin
            m_cnt--;
            if (m_cnt == 0) m_in_flush = 1'b0;
        end
`ifdef BP_STATS_EN
        if (upd && m_bc < 65535) m_bc++;
        if (e.mis && m_mc < 65535) m_mc++;
`endif
        #1;
    endtask

    task automatic br(input string tag, input logic [31:0] pc, input logic tk, input logic ep,
                      input int xp, input int xf, input int xm);
        IF_PC = pc;
        EX_valid = 1'b1;
        EX_isBranch = 1'b1;
        EX_PC = pc + 32'd4;
        EX_taken = tk;
        EX_prediction = ep;
        cyc(tag, xp, xf, xm);
    endtask

    task automatic idle(input string tag, input logic [31:0] pc, input int xp, input int xf);
        IF_PC = pc;
        EX_valid = 1'b0;
        EX_isBranch = 1'b0;
        cyc(tag, xp, xf, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        IF_PC = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pred", 32'(prediction), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        reset = 1'b1;

        // Reset state
        idle("init", 32'h40, 0, 0);
        check("init_bcnt_k", 32'(branch_count), 32'h0);
        check("init_mcnt_k", 32'(mispredict_count), 32'h0);

        // Training: 01 -> 10 (mispredict, flush) -> 11
        br("tr1", 32'h40, 1'b1, 1'b0, 0, 1, 1);
        idle("tr1f", 32'h40, 1, 1);
        idle("tr1e", 32'h40, 1, 0);
        br("tr2", 32'h40, 1'b1, 1'b1, 1, 0, 0);
        idle("idx1", 32'h44, 0, 0);

        // Saturation high
        for (int i = 0; i < 4; i++) br("sat_hi", 32'h40, 1'b1, 1'b1, 1, 0, 0);

        // Down: 11->10->01->00->00
        br("nt1", 32'h40, 1'b0, 1'b1, 1, 1, 1);
        idle("nt1f", 32'h40, 1, 1);
        br("nt2", 32'h40, 1'b0, 1'b1, 1, 1, 1);
        idle("nt2f", 32'h40, 0, 1);
        br("nt3", 32'h40, 1'b0, 1'b0, 0, 0, 0);
        br("nt4", 32'h40, 1'b0, 1'b0, 0, 0, 0);
        // 00 -> 01 keeps prediction 0
        br("sat_lo", 32'h40, 1'b1, 1'b0, 0, 1, 1);
        idle("sat_lof", 32'h40, 0, 1);

        // Mispredict flush; branch in second flush cycle is ignored
        br("mf0", 32'h40, 1'b1, 1'b0, 0, 1, 1);
        br("mf1", 32'h40, 1'b1, 1'b0, 1, 1, 0);
        idle("mf2", 32'h40, 1, 0);
        br("mf3", 32'h40, 1'b0, 1'b1, 1, 1, 1);
        idle("mf4", 32'h40, 0, 1);
        idle("mf5", 32'h40, 0, 0);

        // Stall during FLUSH
        br("st0", 32'h40, 1'b1, 1'b0, 0, 1, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) br("stl", 32'h40, 1'b0, 1'b1, 1, 1, 0);
        stall = 1'b0;
        idle("st4", 32'h40, 1, 1);
        idle("st5", 32'h40, 1, 0);

        // Bring entry 0 back to 01, then same-entry collision
        br("pre", 32'h40, 1'b0, 1'b1, 1, 1, 1);
        idle("pref", 32'h40, 0, 1);
        br("col", 32'h80, 1'b1, 1'b1, 0, 0, 0);
        idle("col1", 32'h80, 1, 0);

        // Reset in the middle of a flush
        br("rm0", 32'h80, 1'b0, 1'b1, 1, 1, 1);
        EX_valid = 1'b0;
        EX_isBranch = 1'b0;
        IF_PC = 32'h40;
        #2;
        reset = 1'b0;
        #1;
        check("rm_flush", 32'(flush), 32'h0);
        check("rm_mis", 32'(mispredict), 32'h0);
        check("rm_pred", 32'(prediction), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle("post", 32'h40, 0, 0);
        check("post_bcnt_k", 32'(branch_count), 32'h0);
        check("post_mcnt_k", 32'(mispredict_count), 32'h0);
        br("post_br", 32'h40, 1'b1, 1'b1, 0, 0, 0);
        idle("post_br1", 32'h40, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
